// File: rtl/baud_gen_frac_if.sv
// Control and tick bundle between a UART and its fractional baud generator.
// Pure wiring, no latency; the generator side drives only registered outputs.
// No backpressure: ticks are single-cycle pulses, consumers must take them when high.
interface baud_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              enable;
  logic              resync;
  logic              div_load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              baud_tick;
  logic              baud_clk;
  logic              cfg_err;

  // UART side: programs the divisor and consumes ticks
  modport master (
    output enable, resync, div_load, div_int, div_frac,
    input  os_tick, baud_tick, baud_clk, cfg_err
  );

  // Generator side
  modport slave (
    input  enable, resync, div_load, div_int, div_frac,
    output os_tick, baud_tick, baud_clk, cfg_err
  );
endinterface

// File: rtl/baud_gen_frac.sv
// Oversample/bit-rate tick generator with integer+fractional divisor (fraction built when BAUD_FRAC_EN is defined).
// First os_tick P edges after enable is sampled high; all outputs registered; cfg_err one cycle after div_load.
// No backpressure: ticks are free-running pulses; divisor changes wait for a bit boundary so no bit is shortened.
module baud_gen_frac #(
  parameter int DIV_W            = 16,
  parameter int FRAC_W           = 4,
  parameter int OVERSAMPLE       = 16,
  parameter int DEFAULT_DIV_INT  = 27,
  parameter int DEFAULT_DIV_FRAC = 2
) (
  input logic            clk_i,
  input logic            reset_i,
  baud_gen_frac_if.slave bus
);

  localparam int              SUB_W    = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] DEF_INT  = DIV_W'(DEFAULT_DIV_INT);
  localparam logic [DIV_W-1:0] MIN_INT  = DIV_W'(2);

  logic [DIV_W-1:0] os_cnt_q, os_cnt_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [DIV_W-1:0] act_int_q, act_int_d;
  logic [DIV_W-1:0] pend_int_q, pend_int_d;
  logic             pend_vld_q, pend_vld_d;
  logic             os_tick_q, os_tick_d;
  logic             baud_tick_q, baud_tick_d;
  logic             baud_clk_q, baud_clk_d;
  logic             cfg_err_q, cfg_err_d;

  logic             carry;
  logic [DIV_W:0]   period_last;
  logic             at_last;
  logic             apply_pend;
  logic             load_bad;
  logic [DIV_W-1:0] load_int;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic [FRAC_W:0]   frac_sum;

  // The accumulator only moves at os_tick, so this sum is stable for the whole period.
  assign frac_sum = {1'b0, frac_acc_q} + {1'b0, act_frac_q};
  assign carry    = frac_sum[FRAC_W];
`else
  logic unused_frac;

  assign carry       = 1'b0;
  assign unused_frac = ^{bus.div_frac, FRAC_W'(DEFAULT_DIV_FRAC)};
`endif

  // Last count of the current period is active_int + carry - 1 (active_int >= 2, no underflow).
  assign period_last = {1'b0, act_int_q} + {{DIV_W{1'b0}}, carry} - {{DIV_W{1'b0}}, 1'b1};
  assign at_last     = ({1'b0, os_cnt_q} == period_last);
  assign load_bad    = (bus.div_int < MIN_INT);
  assign load_int    = load_bad ? MIN_INT : bus.div_int;

  // Next-state: idle/resync/count priority, then divisor apply, then divisor capture.
  always_comb begin
    os_cnt_d    = os_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    act_int_d   = act_int_q;
    pend_int_d  = pend_int_q;
    pend_vld_d  = pend_vld_q;
    os_tick_d   = 1'b0;
    baud_tick_d = 1'b0;
    baud_clk_d  = baud_clk_q;
    cfg_err_d   = 1'b0;
    apply_pend  = 1'b0;
`ifdef BAUD_FRAC_EN
    frac_acc_d  = frac_acc_q;
    act_frac_d  = act_frac_q;
    pend_frac_d = pend_frac_q;
`endif

    if (!bus.enable) begin
      os_cnt_d   = '0;
      sub_cnt_d  = '0;
      baud_clk_d = 1'b0;
      apply_pend = pend_vld_q;
`ifdef BAUD_FRAC_EN
      frac_acc_d = '0;
`endif
    end else if (bus.resync) begin
      // Restart alignment; the tick due this cycle (if any) is dropped on purpose.
      os_cnt_d  = '0;
      sub_cnt_d = '0;
`ifdef BAUD_FRAC_EN
      frac_acc_d = '0;
`endif
    end else if (at_last) begin
      os_cnt_d  = '0;
      os_tick_d = 1'b1;
`ifdef BAUD_FRAC_EN
      frac_acc_d = frac_sum[FRAC_W-1:0];
`endif
      if (sub_cnt_q == SUB_LAST) begin
        sub_cnt_d   = '0;
        baud_tick_d = 1'b1;
        baud_clk_d  = ~baud_clk_q;
        // Bit boundary: safe point to switch rate without shortening a bit.
        apply_pend  = pend_vld_q;
      end else begin
        sub_cnt_d = sub_cnt_q + SUB_W'(1);
      end
    end else begin
      os_cnt_d = os_cnt_q + DIV_W'(1);
    end

    if (apply_pend) begin
      act_int_d  = pend_int_q;
      pend_vld_d = 1'b0;
`ifdef BAUD_FRAC_EN
      act_frac_d = pend_frac_q;
`endif
    end

    // A fresh load always wins over an apply in the same cycle, and the last load wins.
    if (bus.div_load) begin
      pend_int_d = load_int;
      pend_vld_d = 1'b1;
      cfg_err_d  = load_bad;
`ifdef BAUD_FRAC_EN
      pend_frac_d = bus.div_frac;
`endif
    end
  end

  // State registers with synchronous reset to the default divisor.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      os_cnt_q    <= '0;
      sub_cnt_q   <= '0;
      act_int_q   <= DEF_INT;
      pend_int_q  <= DEF_INT;
      pend_vld_q  <= 1'b0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      baud_clk_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef BAUD_FRAC_EN
      frac_acc_q  <= '0;
      act_frac_q  <= FRAC_W'(DEFAULT_DIV_FRAC);
      pend_frac_q <= FRAC_W'(DEFAULT_DIV_FRAC);
`endif
    end else begin
      os_cnt_q    <= os_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      act_int_q   <= act_int_d;
      pend_int_q  <= pend_int_d;
      pend_vld_q  <= pend_vld_d;
      os_tick_q   <= os_tick_d;
      baud_tick_q <= baud_tick_d;
      baud_clk_q  <= baud_clk_d;
      cfg_err_q   <= cfg_err_d;
`ifdef BAUD_FRAC_EN
      frac_acc_q  <= frac_acc_d;
      act_frac_q  <= act_frac_d;
      pend_frac_q <= pend_frac_d;
`endif
    end
  end

  assign bus.os_tick   = os_tick_q;
  assign bus.baud_tick = baud_tick_q;
  assign bus.baud_clk  = baud_clk_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: an event-level period model predicts each tick edge into a queue,
// a negedge monitor pops and compares whenever a tick appears.
// Edge numbers: cyc counts rising edges; a value driven at negedge n is sampled at edge n+1.
module tb_baud_gen_frac;
  localparam int DIV_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OVS      = 16;
  localparam int FR       = 16;
  localparam int DEF_INT  = 27;
  localparam int DEF_FRAC = 2;
`ifdef BAUD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif
  localparam int DEF_BIT = FRAC_ON ? 434 : 432;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  baud_gen_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bif ();

  baud_gen_frac #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OVS),
    .DEFAULT_DIV_INT(DEF_INT), .DEFAULT_DIV_FRAC(DEF_FRAC)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .bus(bif.slave)
  );

  typedef struct {
    int t;
    bit baud;
    bit bclk;
  } exp_t;

  exp_t exp_q[$];
  int   os_hist[$];
  int   baud_hist[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: active/pending divisor, fractional accumulator,
  // position within the bit, edge of the last predicted tick.
  int m_ai, m_af, m_pi, m_pf, m_acc, m_sub, m_t;
  bit m_pv, m_bclk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int p_next();
    return m_ai + (FRAC_ON ? (m_acc + m_af) / FR : 0);
  endfunction

  task automatic model_apply();
    if (m_pv) begin
      m_ai = m_pi;
      m_af = m_pf;
      m_pv = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ai = DEF_INT;  m_af = FRAC_ON ? DEF_FRAC : 0;
    m_pi = DEF_INT;  m_pf = m_af;  m_pv = 1'b0;
    m_acc = 0;  m_sub = 0;  m_bclk = 1'b0;
  endtask

  // Predict the next n os_ticks from the divisor rules.
  task automatic plan(int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int   p;
      p     = p_next();
      m_acc = FRAC_ON ? (m_acc + m_af) % FR : 0;
      m_t   = m_t + p;
      m_sub = m_sub + 1;
      e.baud = 1'b0;
      if (m_sub == OVS) begin
        m_sub  = 0;
        e.baud = 1'b1;
        m_bclk = ~m_bclk;
        model_apply();
      end
      e.t    = m_t;
      e.bclk = m_bclk;
      exp_q.push_back(e);
    end
  endtask

  task automatic plan_until(int lim);
    while (m_t + p_next() <= lim) plan(1);
  endtask

  task automatic goto(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic clear_hist();
    os_hist.delete();
    baud_hist.delete();
  endtask

  // One-cycle div_load strobe plus the cfg_err pulse check that follows it.
  task automatic do_load(int di, int df);
    bif.div_int  = di[DIV_W-1:0];
    bif.div_frac = df[FRAC_W-1:0];
    bif.div_load = 1'b1;
    @(negedge clk);
    bif.div_load = 1'b0;
    m_pi = (di < 2) ? 2 : di;
    m_pf = FRAC_ON ? df : 0;
    m_pv = 1'b1;
    if (!bif.enable) model_apply();
    chk("cfg_err_pulse", int'(bif.cfg_err), (di < 2) ? 1 : 0);
    @(negedge clk);
    chk("cfg_err_clear", int'(bif.cfg_err), 0);
  endtask

  // Advance to a point inside a bit (sub 1..10) right after the last predicted tick.
  task automatic to_midbit();
    plan(int'($urandom_range(1, 8)));
    while (m_sub == 0 || m_sub > 10) plan(1);
    goto(m_t + 1);
  endtask

  // Monitor: every tick seen must be the next predicted one.
  always @(negedge clk) begin
    if (!reset && (bif.os_tick || bif.baud_tick)) begin
      exp_t e;
      if (bif.os_tick) os_hist.push_back(cyc);
      if (bif.baud_tick) baud_hist.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: tick at edge %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("tick_edge", cyc, e.t);
        chk("tick_os", int'(bif.os_tick), 1);
        chk("tick_baud", int'(bif.baud_tick), int'(e.baud));
        chk("tick_bclk", int'(bif.baud_clk), int'(e.bclk));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded time limit at edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    int r, n28, prev, pe, di, df, sz;
    bif.enable = 1'b0;  bif.resync = 1'b0;  bif.div_load = 1'b0;
    bif.div_int = '0;   bif.div_frac = '0;
    model_reset();

    // Reset state
    goto(2);
    chk("rst_os_tick", int'(bif.os_tick), 0);
    chk("rst_baud_tick", int'(bif.baud_tick), 0);
    chk("rst_baud_clk", int'(bif.baud_clk), 0);
    chk("rst_cfg_err", int'(bif.cfg_err), 0);

    // Default divisor, three bits
    goto(3);
    reset = 1'b0;
    bif.enable = 1'b1;
    m_t = 3;
    clear_hist();
    plan(3 * OVS);
    goto(m_t + 1);
    chk("s1_drained", exp_q.size(), 0);
    chk("s1_os_count", os_hist.size(), 3 * OVS);
    chk("s1_baud_count", baud_hist.size(), 3);
    if (baud_hist.size() >= 2) begin
      chk("s1_first_bit", baud_hist[0] - 3, DEF_BIT);
      chk("s1_bit_period", baud_hist[1] - baud_hist[0], DEF_BIT);
    end
    if (os_hist.size() >= OVS) begin
      n28 = 0;
      prev = 3;
      for (int k = 0; k < OVS; k++) begin
        if (os_hist[k] - prev == 28) n28++;
        prev = os_hist[k];
      end
      chk("s1_long_periods", n28, FRAC_ON ? 2 : 0);
    end

    // Enable dropped 10 clocks into a period for 5 clocks
    goto(m_t + 9);
    bif.enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("dis_baud_clk", int'(bif.baud_clk), 0);
      chk("dis_os_tick", int'(bif.os_tick), 0);
    end
    bif.enable = 1'b1;
    r = cyc;
    m_acc = 0;  m_sub = 0;  m_bclk = 1'b0;
    model_apply();
    m_t = r;
    clear_hist();
    plan(OVS);
    goto(m_t + 1);
    chk("en_drained", exp_q.size(), 0);
    if (os_hist.size() > 0) chk("en_first_os", os_hist[0] - r, DEF_INT);
    else chk("en_first_os_seen", 0, 1);

    // Resync on the last count of a period
    plan(5);
    pe = p_next();
    goto(m_t + pe - 1);
    bif.resync = 1'b1;
    @(negedge clk);
    bif.resync = 1'b0;
    r = cyc;
    chk("rs_no_tick", int'(bif.os_tick), 0);
    chk("rs_baud_clk_kept", int'(bif.baud_clk), int'(m_bclk));
    m_acc = 0;  m_sub = 0;  m_t = r;
    clear_hist();
    pe = m_ai;
    plan(OVS);
    goto(m_t + 1);
    chk("rs_drained", exp_q.size(), 0);
    if (os_hist.size() > 0 && baud_hist.size() > 0) begin
      chk("rs_first_os", os_hist[0] - r, pe);
      chk("rs_first_baud", baud_hist[0] - r, DEF_BIT);
    end else chk("rs_ticks_seen", 0, 1);

    // Mid-bit divisor loads: fixed cases, invalid int, random, back-to-back
    for (int it = 0; it < 4; it++) begin
      case (it)
        0: begin di = 3; df = 0; end
        1: begin di = 0; df = 0; end
        default: begin di = int'($urandom_range(2, 9)); df = int'($urandom_range(0, 15)); end
      endcase
      to_midbit();
      plan_until(cyc + 6);
      if (it == 3) do_load(int'($urandom_range(0, 9)), int'($urandom_range(0, 15)));
      do_load(di, df);
      clear_hist();
      plan(OVS - m_sub);
      plan(2 * OVS);
      goto(m_t + 1);
      chk("ld_drained", exp_q.size(), 0);
      sz = baud_hist.size();
      chk("ld_baud_count", sz, 3);
      if (sz >= 2)
        chk("ld_bit_period", baud_hist[sz-1] - baud_hist[sz-2],
            OVS * ((di < 2) ? 2 : di) + (FRAC_ON ? df : 0));
      if (it < 2 && os_hist.size() >= 2)
        chk("ld_os_period", os_hist[os_hist.size()-1] - os_hist[os_hist.size()-2], (di < 2) ? 2 : di);
    end

    // Load while disabled takes effect before re-enable
    bif.enable = 1'b0;
    @(negedge clk);
    do_load(4, 0);
    bif.enable = 1'b1;
    r = cyc;
    m_acc = 0;  m_sub = 0;  m_bclk = 1'b0;  m_t = r;
    clear_hist();
    plan(OVS);
    goto(m_t + 1);
    chk("dl_drained", exp_q.size(), 0);
    if (os_hist.size() > 0 && baud_hist.size() > 0) begin
      chk("dl_first_os", os_hist[0] - r, 4);
      chk("dl_first_baud", baud_hist[0] - r, OVS * 4);
    end else chk("dl_ticks_seen", 0, 1);

    // Reset mid-bit after loading 5 restores defaults
    to_midbit();
    plan_until(cyc + 2);
    do_load(5, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_os_tick", int'(bif.os_tick), 0);
    chk("mr_baud_tick", int'(bif.baud_tick), 0);
    chk("mr_baud_clk", int'(bif.baud_clk), 0);
    chk("mr_cfg_err", int'(bif.cfg_err), 0);
    chk("mr_no_stale_exp", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b0;
    r = cyc;
    model_reset();
    m_t = r;
    clear_hist();
    plan(2 * OVS);
    goto(m_t + 1);
    chk("mr_drained", exp_q.size(), 0);
    if (baud_hist.size() >= 2) begin
      chk("mr_first_bit", baud_hist[0] - r, DEF_BIT);
      chk("mr_bit_period", baud_hist[1] - baud_hist[0], DEF_BIT);
    end else chk("mr_baud_seen", baud_hist.size(), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
